uart_frame_decoder: RTL and testbench

Module-side receiver for the two-byte sine-index frame that the main FPGA broadcasts over each UART link. It sits after `uart_rx` on every power module and reassembles byte 1 = {uart_id[3:0], sin_index[11:8]} and byte 2 = sin_index[7:0]. It filters frames by module ID, validates the index range and resynchronises after lost bytes using an inter-byte timeout. It presents a registered `sin_index` with a one-cycle valid strobe to the local sine-table / PWM logic.

---
 rtl/uart_frame_decoder.sv | 154 +++++++++++++++
 tb/tb_uart_frame_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_decoder.sv
// Reassembles the two-byte {id, sin_index} UART frame, filters by module ID,
// range-checks the index and drops a half frame after an inter-byte timeout.
module uart_frame_decoder #(
  parameter logic [3:0]  MODULE_ID      = 4'h1,
  parameter logic [3:0]  BROADCAST_ID   = 4'hF,
  parameter int unsigned TABLE_LEN      = 3072,
  parameter int unsigned TIMEOUT_CYCLES = 2400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_done,
  input  logic        rx_parity_error,
  output logic [11:0] sin_index,
  output logic [3:0]  frame_id,
  output logic        frame_valid,
  output logic        busy,
  output logic        frame_error,
  output logic [1:0]  error_code,
  output logic [7:0]  error_count
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_RANGE   = 2'b11;

  typedef enum logic [0:0] {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0] sin_index_q, sin_index_d;
  logic [3:0]  frame_id_q, frame_id_d;
  logic        frame_valid_q, frame_valid_d;
  logic        busy_q, busy_d;
  logic        frame_error_q, frame_error_d;
  logic [1:0]  error_code_q, error_code_d;
  logic [7:0]  error_count_q, error_count_d;

  logic [11:0] idx_s;
  logic [3:0]  id_s;
  logic        err_raise_s;

  assign idx_s = {hi_q[3:0], rx_byte};
  assign id_s  = hi_q[7:4];

  // Next-state, frame assembly and error classification.
  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    cnt_d         = cnt_q;
    sin_index_d   = sin_index_q;
    frame_id_d    = frame_id_q;
    frame_valid_d = 1'b0;
    error_code_d  = error_code_q;
    err_raise_s   = 1'b0;

    case (state_q)
      WAIT_HI: begin
        if (rx_done && rx_parity_error) begin
          err_raise_s  = 1'b1;
          error_code_d = ERR_PARITY;
        end else if (rx_done) begin
          hi_d    = rx_byte;
          cnt_d   = '0;
          state_d = WAIT_LO;
        end else begin
          state_d = WAIT_HI;
        end
      end
      WAIT_LO: begin
        if (rx_done) begin
          // A byte in the expiry cycle still completes the frame.
          state_d = WAIT_HI;
          cnt_d   = '0;
          if (rx_parity_error) begin
            err_raise_s  = 1'b1;
            error_code_d = ERR_PARITY;
          end else if ((id_s != MODULE_ID) && (id_s != BROADCAST_ID)) begin
            frame_valid_d = 1'b0;
          end else if (32'(idx_s) >= TABLE_LEN) begin
            err_raise_s  = 1'b1;
            error_code_d = ERR_RANGE;
          end else begin
            sin_index_d   = idx_s;
            frame_id_d    = id_s;
            frame_valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_raise_s  = 1'b1;
          error_code_d = ERR_TIMEOUT;
          cnt_d        = '0;
          state_d      = WAIT_HI;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = WAIT_HI;
        cnt_d   = '0;
      end
    endcase

    frame_error_d = err_raise_s;
    if (err_raise_s && (error_count_q != 8'hFF)) begin
      error_count_d = error_count_q + 8'd1;
    end else begin
      error_count_d = error_count_q;
    end
    busy_d = (state_d == WAIT_LO);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WAIT_HI;
      hi_q          <= 8'h00;
      cnt_q         <= '0;
      sin_index_q   <= 12'h000;
      frame_id_q    <= 4'h0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_error_q <= 1'b0;
      error_code_q  <= 2'b00;
      error_count_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      cnt_q         <= cnt_d;
      sin_index_q   <= sin_index_d;
      frame_id_q    <= frame_id_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
      frame_error_q <= frame_error_d;
      error_code_q  <= error_code_d;
      error_count_q <= error_count_d;
    end
  end

  assign sin_index   = sin_index_q;
  assign frame_id    = frame_id_q;
  assign frame_valid = frame_valid_q;
  assign busy        = busy_q;
  assign frame_error = frame_error_q;
  assign error_code  = error_code_q;
  assign error_count = error_count_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Bench for uart_frame_decoder: directed frames plus random byte streams,
// checked by a queue-based scoreboard fed from a time-based frame model.
module tb_uart_frame_decoder;

  localparam int N    = 64;
  localparam int TLEN = 3072;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_done = 1'b0;
  logic        rx_parity_error = 1'b0;
  logic [11:0] sin_index;
  logic [3:0]  frame_id;
  logic        frame_valid;
  logic        busy;
  logic        frame_error;
  logic [1:0]  error_code;
  logic [7:0]  error_count;

  uart_frame_decoder #(
    .MODULE_ID(4'h1), .BROADCAST_ID(4'hF), .TABLE_LEN(TLEN), .TIMEOUT_CYCLES(N)
  ) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_done(rx_done),
    .rx_parity_error(rx_parity_error), .sin_index(sin_index), .frame_id(frame_id),
    .frame_valid(frame_valid), .busy(busy), .frame_error(frame_error),
    .error_code(error_code), .error_count(error_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    bit         is_err;
    logic [11:0] sin;
    logic [3:0]  id;
    logic [1:0]  code;
    logic [7:0]  cnt;
  } ev_t;

  ev_t evq[$];
  bit  exp_busy[int];

  // reference model state: pending byte 1 and the cycle it arrived
  bit          m_pend;
  logic [7:0]  m_hi;
  int          m_thi;
  logic [11:0] m_sin;
  logic [3:0]  m_id;
  logic [1:0]  m_code;
  int          m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset(input int s);
    m_pend = 1'b0; m_hi = 8'h00; m_thi = 0;
    m_sin = 12'h000; m_id = 4'h0; m_code = 2'b00; m_cnt = 0;
    exp_busy[s] = 1'b0;
  endtask

  // Expected behaviour for the input sampled at clock edge s.
  task automatic model_step(input int s, input bit done, input logic [7:0] b, input bit pe);
    bit err = 1'b0;
    bit ok  = 1'b0;
    logic [3:0]  id;
    logic [11:0] idx;
    ev_t e;
    if (m_pend && !done && (s == m_thi + N)) begin
      err = 1'b1; m_code = 2'b10; m_pend = 1'b0;
    end else if (done) begin
      if (pe) begin
        err = 1'b1; m_code = 2'b01; m_pend = 1'b0;
      end else if (!m_pend) begin
        m_pend = 1'b1; m_hi = b; m_thi = s;
      end else begin
        m_pend = 1'b0;
        id  = m_hi[7:4];
        idx = {m_hi[3:0], b};
        if (id == 4'h1 || id == 4'hF) begin
          if (int'(idx) >= TLEN) begin
            err = 1'b1; m_code = 2'b11;
          end else begin
            m_sin = idx; m_id = id; ok = 1'b1;
          end
        end
      end
    end
    if (err && m_cnt < 255) m_cnt++;
    if (err || ok) begin
      e.cyc = s; e.is_err = err; e.sin = m_sin; e.id = m_id;
      e.code = m_code; e.cnt = 8'(m_cnt);
      evq.push_back(e);
    end
    exp_busy[s] = m_pend;
  endtask

  // One clock of stimulus; returns 1 time unit after the sampling edge.
  task automatic drive(input bit done, input logic [7:0] b, input bit pe);
    model_step(cyc + 1, done, b, pe);
    rx_done = done; rx_byte = b; rx_parity_error = pe;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'($urandom));
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, b, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      model_reset(cyc + 1);
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_sin"}, sin_index, 12'h000);
    chk({tag, "_id"}, frame_id, 4'h0);
    chk({tag, "_valid"}, frame_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ferr"}, frame_error, 1'b0);
    chk({tag, "_code"}, error_code, 2'b00);
    chk({tag, "_cnt"}, error_count, 8'h00);
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT pulses an output.
  always @(negedge clk) begin
    ev_t e;
    if (frame_valid === 1'b1 || frame_error === 1'b1) begin
      if (evq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse: valid=%0b error=%0b with empty queue (cycle %0d)",
                 frame_valid, frame_error, cyc);
      end else begin
        e = evq.pop_front();
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_valid", frame_valid, !e.is_err);
        chk("ev_error", frame_error, e.is_err);
        chk("ev_sin", sin_index, e.sin);
        chk("ev_id", frame_id, e.id);
        chk("ev_code", error_code, e.code);
        chk("ev_count", error_count, e.cnt);
      end
    end
    if (exp_busy.exists(cyc)) begin
      chk("busy", busy, exp_busy[cyc]);
      exp_busy.delete(cyc);
    end
  end

  initial begin
    int gap;
    logic [7:0] b;
    do_reset(3);
    chk_reset_state("reset");

    send(8'h1A); send(8'h3C);
    chk("normal_valid", frame_valid, 1'b1);
    chk("normal_sin", sin_index, 12'hA3C);
    chk("normal_id", frame_id, 4'h1);

    send(8'h2A); send(8'h3C);
    chk("filter_novalid", frame_valid, 1'b0);
    chk("filter_noerr", frame_error, 1'b0);
    chk("filter_sin", sin_index, 12'hA3C);

    idle(2);
    send(8'hF0); send(8'h05);
    chk("bcast_sin", sin_index, 12'h005);
    chk("bcast_id", frame_id, 4'hF);

    send(8'h1C); send(8'h00);
    chk("range_err", frame_error, 1'b1);
    chk("range_code", error_code, 2'b11);
    chk("range_sin", sin_index, 12'h005);
    send(8'h1B); send(8'hFF);
    chk("range_max_sin", sin_index, 12'hBFF);

    send(8'h11); idle(N);
    chk("timeout_err", frame_error, 1'b1);
    chk("timeout_code", error_code, 2'b10);
    chk("timeout_busy", busy, 1'b0);
    send(8'h10); send(8'h20);
    chk("resync_sin", sin_index, 12'h020);

    send(8'h15); idle(N - 1); send(8'h55);
    chk("edge_valid", frame_valid, 1'b1);
    chk("edge_noerr", frame_error, 1'b0);
    chk("edge_sin", sin_index, 12'h555);

    send(8'h1A); drive(1'b1, 8'h3C, 1'b1);
    chk("par2_code", error_code, 2'b01);
    send(8'h12); send(8'h34);
    chk("par2_sin", sin_index, 12'h234);

    for (int i = 0; i < 300; i++) drive(1'b1, 8'($urandom), 1'b1);
    chk("sat_count", error_count, 8'hFF);

    send(8'h1A); idle(2);
    do_reset(2);
    chk_reset_state("midreset");
    send(8'h13); send(8'h45);
    chk("post_reset_sin", sin_index, 12'h345);

    for (int k = 0; k < 400; k++) begin
      gap = $urandom_range(0, 9);
      if (gap < 6) gap = gap % 3;
      else if (gap < 8) gap = $urandom_range(N - 3, N + 1);
      else gap = $urandom_range(3, 20);
      idle(gap);
      case ($urandom_range(0, 3))
        0: b = {4'h1, 4'($urandom)};
        1: b = {4'hF, 4'($urandom)};
        2: b = 8'($urandom);
        default: b = {4'h1, ($urandom_range(0, 1) == 0) ? 4'hB : 4'hC};
      endcase
      drive(1'b1, b, $urandom_range(0, 9) == 0);
    end

    idle(N + 2);
    @(negedge clk);
    #1;
    chk("queue_empty", evq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
